lcd_spi_receiver: RTL and testbench
===================================

LCD_SPI_RECEIVER -- requirements
Module: lcd_spi_receiver

Interface
REQ-001 SHALL have parameter X_MAX, default 84, columns per bank.
REQ-002 SHALL have parameter Y_MAX, default 6, banks (8-pixel rows).
REQ-003 SHALL have port clock  in  1  system clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports sclk, sdin, sce, dc, res  in  1 each  LCD serial link: sclk and sdin MSB-first, sce active-low select, dc 1=data/0=command, res active-low LCD reset; all asynchronous to clock.
REQ-006 SHALL have port byte_valid  out  1  one-cycle pulse per completed byte.
REQ-007 SHALL have ports byte_data  out  8  received byte, and byte_dc  out  1  dc sampled with that byte.
REQ-008 SHALL have ports x_addr  out  7  and y_addr  out  3  current write pointer.
REQ-009 SHALL have ports power_down, vaddr_mode, ext_mode  out  1 each  decoded PD, V, H bits.
REQ-010 SHALL have port vop  out  7  last Vop value written in extended mode.
REQ-011 SHALL have ports frame_err and cmd_err  out  1 each  one-cycle error pulses.
REQ-012 SHALL have ports rd_addr  in  9  and rd_data  out  8  framebuffer read port, address = y*X_MAX + x.

Function
REQ-013 SHALL pass sclk, sdin, sce, dc and res through identical 2-flop synchronizers and detect sclk rising edges on the synchronized copy.
REQ-014 SHALL shift the synchronized sdin into a shift register on each detected sclk rise while synchronized sce=0; SHALL ignore sclk edges while sce=1.
REQ-015 SHALL complete a byte on the 8th rise, assert byte_valid 3 clock cycles after that sclk rise at the pins, and clear the bit count.
REQ-016 SHALL sample dc on the 8th rise into byte_dc.
REQ-017 SHALL, on sce rising with bit count 1..7, discard the partial byte, clear the bit count and pulse frame_err; sce rising at count 0 SHALL be silent.
REQ-018 SHALL decode command bytes (dc=0): 0b00100PVH (any H) updates power_down, vaddr_mode, ext_mode; with H=0, 0b01000yyy sets y_addr and 0b1xxxxxxx sets x_addr; with H=1, 0b1vvvvvvv sets vop; all other codes are accepted without effect.
REQ-019 SHALL ignore set-X with value >= X_MAX and set-Y with value >= Y_MAX, leaving the pointer unchanged and pulsing cmd_err.
REQ-020 SHALL, for data bytes (dc=1), write byte_data at the pointer in the cycle byte_valid asserts, then advance the pointer.
REQ-021 SHALL advance in horizontal mode (V=0): x+1; at x=X_MAX-1, x=0 and y+1; at (X_MAX-1, Y_MAX-1), wrap to (0,0).
REQ-022 SHALL advance in vertical mode (V=1): y+1; at y=Y_MAX-1, y=0 and x+1; at (X_MAX-1, Y_MAX-1), wrap to (0,0).
REQ-023 SHALL return rd_data one cycle after rd_addr; a read and write to the same address in one cycle SHALL return the old contents.
REQ-024 SHALL treat synchronized res=0 as LCD reset: bit count, x_addr, y_addr and vop to 0; power_down=1, vaddr_mode=0, ext_mode=0; framebuffer unchanged; no bytes accepted while res=0.

Reset
REQ-025 SHALL, on Reset=1 at a clock edge, clear synchronizers to idle (sce=1, res=1, sclk=0), bit count and shift register to 0, byte_valid, frame_err and cmd_err to 0, byte_data=0x00, byte_dc=0, x_addr=0, y_addr=0, vop=0, power_down=1, vaddr_mode=0, ext_mode=0.
REQ-026 SHALL NOT clear framebuffer contents on Reset; Reset asserted mid-byte SHALL drop the byte without frame_err.

Configuration
REQ-027 SHALL, with LCD_RX_FRAMEBUFFER_EN defined, include the X_MAX*Y_MAX x 8 framebuffer and read port as specified.
REQ-028 SHALL, without LCD_RX_FRAMEBUFFER_EN, omit the memory, tie rd_data to 0x00, and keep all pointer and decode behaviour identical.

Verification
REQ-029 Reset, then with sce=0 and dc=0 send 0x21, 0xBF, 0x20 -> ext_mode 1 then 0, vop=0x3F, power_down=0, three byte_valid pulses.
REQ-030 Send cmd 0x45, 0xD3 then data 0xA5 -> y=5, x=83 at write; pointer wraps to (0,0); rd_addr=503 reads 0xA5.
REQ-031 Send cmd 0x22 (V=1), set x=0, y=5, data 0x11, 0x22 -> 0x11 at addr 420, 0x22 at addr 1; pointer ends at x=1, y=1.
REQ-032 Raise sce after 5 bits, then send full byte 0x5A -> one frame_err pulse, then byte_data=0x5A with no corruption.
REQ-033 Send cmd 0x47 and 0xD4 -> two cmd_err pulses, pointer unchanged.
REQ-034 Pulse res low mid-session -> x=0, y=0, power_down=1, vop=0; prior framebuffer data still readable (macro defined) or rd_data=0x00 (macro undefined).

Source files
------------

// File: rtl/lcd_spi_receiver_if.sv
// Serial link from the LCD controller plus the received-byte stream.
// The receiver owns the byte stream; whoever drives the link uses the master side.
interface lcd_spi_receiver_if;
    logic       sclk;
    logic       sdin;
    logic       sce;
    logic       dc;
    logic       res;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;

    modport master (
        output sclk, sdin, sce, dc, res,
        input  byte_valid, byte_data, byte_dc
    );

    modport slave (
        input  sclk, sdin, sce, dc, res,
        output byte_valid, byte_data, byte_dc
    );
endinterface

// File: rtl/lcd_spi_receiver.sv
// PCD8544-style LCD serial receiver: byte assembly, command decode, write pointer
// and optional framebuffer (define LCD_RX_FRAMEBUFFER_EN to include the memory).
module lcd_spi_receiver #(
    parameter int X_MAX = 84,
    parameter int Y_MAX = 6
) (
    input  logic                clock,
    input  logic                Reset,
    lcd_spi_receiver_if.slave   lnk,
    output logic [6:0]          x_addr,
    output logic [2:0]          y_addr,
    output logic                power_down,
    output logic                vaddr_mode,
    output logic                ext_mode,
    output logic [6:0]          vop,
    output logic                frame_err,
    output logic                cmd_err,
    input  logic [8:0]          rd_addr,
    output logic [7:0]          rd_data
);

    // Bit order {res, dc, sce, sdin, sclk}; idle = LCD out of reset, deselected, clock low.
    localparam logic [4:0] SYNC_IDLE = 5'b10100;
    localparam logic [6:0] X_LAST    = 7'(X_MAX - 1);
    localparam logic [2:0] Y_LAST    = 3'(Y_MAX - 1);

    logic [4:0] sync1, sync2;
    logic       sclk_q, sce_q;
    logic       sclk_s, sdin_s, sce_s, dc_s, res_s;
    logic       sclk_rise, sce_rise;
    logic [2:0] bit_cnt;
    logic [6:0] shift_q;

    assign sclk_s    = sync2[0];
    assign sdin_s    = sync2[1];
    assign sce_s     = sync2[2];
    assign dc_s      = sync2[3];
    assign res_s     = sync2[4];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sce_rise  = sce_s & ~sce_q;

    always_ff @(posedge clock) begin
        if (Reset) begin
            sync1          <= SYNC_IDLE;
            sync2          <= SYNC_IDLE;
            sclk_q         <= 1'b0;
            sce_q          <= 1'b1;
            bit_cnt        <= '0;
            shift_q        <= '0;
            lnk.byte_valid <= 1'b0;
            lnk.byte_data  <= 8'h00;
            lnk.byte_dc    <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            sync1          <= {lnk.res, lnk.dc, lnk.sce, lnk.sdin, lnk.sclk};
            sync2          <= sync1;
            sclk_q         <= sclk_s;
            sce_q          <= sce_s;
            lnk.byte_valid <= 1'b0;
            frame_err      <= 1'b0;
            if (!res_s) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (sce_rise && bit_cnt != 3'd0) begin
                bit_cnt   <= '0;
                frame_err <= 1'b1;
            end else if (sclk_rise && !sce_s) begin
                if (bit_cnt == 3'd7) begin
                    lnk.byte_data  <= {shift_q, sdin_s};
                    lnk.byte_dc    <= dc_s;
                    lnk.byte_valid <= 1'b1;
                    bit_cnt        <= '0;
                end else begin
                    shift_q <= {shift_q[5:0], sdin_s};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    logic [6:0] x_next;
    logic [2:0] y_next;
    logic       is_func, is_sety, is_setx, is_vop;

    always_comb begin
        x_next = x_addr;
        y_next = y_addr;
        if (!vaddr_mode) begin
            if (x_addr == X_LAST) begin
                x_next = '0;
                y_next = (y_addr == Y_LAST) ? 3'd0 : y_addr + 3'd1;
            end else begin
                x_next = x_addr + 7'd1;
            end
        end else begin
            if (y_addr == Y_LAST) begin
                y_next = '0;
                x_next = (x_addr == X_LAST) ? 7'd0 : x_addr + 7'd1;
            end else begin
                y_next = y_addr + 3'd1;
            end
        end
    end

    always_comb begin
        is_func = (lnk.byte_data[7:3] == 5'b00100);
        is_sety = !ext_mode && (lnk.byte_data[7:3] == 5'b01000);
        is_setx = !ext_mode && lnk.byte_data[7];
        is_vop  = ext_mode && lnk.byte_data[7];
    end

    // LCD reset (res low) behaves like Reset for the control state but spares the framebuffer.
    always_ff @(posedge clock) begin
        if (Reset || !res_s) begin
            x_addr     <= '0;
            y_addr     <= '0;
            vop        <= '0;
            power_down <= 1'b1;
            vaddr_mode <= 1'b0;
            ext_mode   <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (lnk.byte_valid) begin
                if (lnk.byte_dc) begin
                    x_addr <= x_next;
                    y_addr <= y_next;
                end else if (is_func) begin
                    power_down <= lnk.byte_data[2];
                    vaddr_mode <= lnk.byte_data[1];
                    ext_mode   <= lnk.byte_data[0];
                end else if (is_sety) begin
                    if (lnk.byte_data[2:0] > Y_LAST) cmd_err <= 1'b1;
                    else                             y_addr  <= lnk.byte_data[2:0];
                end else if (is_setx) begin
                    if (lnk.byte_data[6:0] > X_LAST) cmd_err <= 1'b1;
                    else                             x_addr  <= lnk.byte_data[6:0];
                end else if (is_vop) begin
                    vop <= lnk.byte_data[6:0];
                end
            end
        end
    end

`ifdef LCD_RX_FRAMEBUFFER_EN
    localparam int         DEPTH  = X_MAX * Y_MAX;
    localparam logic [8:0] X_MAX9 = 9'(X_MAX);

    logic [7:0] fb [DEPTH];
    logic [8:0] wr_addr;
    logic       fb_we;

    assign wr_addr = 9'(y_addr) * X_MAX9 + 9'(x_addr);
    assign fb_we   = lnk.byte_valid && lnk.byte_dc && res_s && !Reset;

    // No reset here: contents survive both Reset and LCD reset; reads see pre-write data.
    always_ff @(posedge clock) begin
        if (fb_we) fb[wr_addr] <= lnk.byte_data;
        rd_data <= fb[rd_addr];
    end
`else
    logic unused_rd;

    assign rd_data   = 8'h00;
    assign unused_rd = ^rd_addr;
`endif

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Directed bench for lcd_spi_receiver: stimulus pushes expected bytes to a
// scoreboard that a negedge monitor pops whenever byte_valid is seen.
module tb_lcd_spi_receiver;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        bit         chk;
        logic [6:0] x;
        logic [2:0] y;
    } exp_t;

    logic       clock = 1'b0;
    logic       Reset;
    logic [6:0] x_addr, vop;
    logic [2:0] y_addr;
    logic       power_down, vaddr_mode, ext_mode, frame_err, cmd_err;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;

    int   tests = 0;
    int   fails = 0;
    int   fe_cnt = 0, ce_cnt = 0, bv_cnt = 0;
    int   fe0, ce0, bv0;
    exp_t sb[$];

`ifdef LCD_RX_FRAMEBUFFER_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    lcd_spi_receiver_if lnk ();

    lcd_spi_receiver #(.X_MAX(84), .Y_MAX(6)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .lnk        (lnk),
        .x_addr     (x_addr),
        .y_addr     (y_addr),
        .power_down (power_down),
        .vaddr_mode (vaddr_mode),
        .ext_mode   (ext_mode),
        .vop        (vop),
        .frame_err  (frame_err),
        .cmd_err    (cmd_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Serial bits MSB-first; optionally measures byte_valid latency from the 8th rise.
    task automatic send_bits(input logic [7:0] b, input int n, input logic dcv, input bit chk_lat);
        int lat;
        for (int i = 0; i < n; i++) begin
            lnk.sdin = b[7-i];
            lnk.dc   = dcv;
            wait_clk(3);
            lnk.sclk = 1'b1;
            if (chk_lat && i == 7) begin
                lat = 0;
                while (lat < 10 && !lnk.byte_valid) begin
                    @(negedge clock);
                    lat++;
                end
                check("byte_valid_latency", lat, 4);
                wait_clk(2);
            end else begin
                wait_clk(3);
            end
            lnk.sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dcv, input bit chk,
                             input logic [6:0] ex, input logic [2:0] ey);
        exp_t e;
        e.dc = dcv; e.data = b; e.chk = chk; e.x = ex; e.y = ey;
        sb.push_back(e);
        send_bits(b, 8, dcv, 1'b1);
        wait_clk(4);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(b, 1'b0, 1'b0, 7'd0, 3'd0);
    endtask

    task automatic read_fb(input logic [8:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        wait_clk(2);
        check(name, rd_data, exp);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (lnk.byte_valid) begin
            bv_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got 0x%0h, none expected", lnk.byte_data);
            end else begin
                e = sb.pop_front();
                check("byte_data", lnk.byte_data, e.data);
                check("byte_dc", lnk.byte_dc, e.dc);
                if (e.chk) begin
                    check("write_x", x_addr, e.x);
                    check("write_y", y_addr, e.y);
                end
            end
        end
        if (frame_err) fe_cnt++;
        if (cmd_err)   ce_cnt++;
    end

    initial begin
        lnk.sclk = 1'b0; lnk.sdin = 1'b0; lnk.sce = 1'b1; lnk.dc = 1'b0; lnk.res = 1'b1;
        rd_addr = '0;
        Reset = 1'b1;
        wait_clk(3);
        check("rst_x", x_addr, 0);
        check("rst_y", y_addr, 0);
        check("rst_pd", power_down, 1);
        check("rst_v", vaddr_mode, 0);
        check("rst_h", ext_mode, 0);
        check("rst_vop", vop, 0);
        check("rst_byte_valid", lnk.byte_valid, 0);
        check("rst_byte_data", lnk.byte_data, 8'h00);
        check("rst_byte_dc", lnk.byte_dc, 0);
        check("rst_errs", {frame_err, cmd_err}, 0);
        Reset = 1'b0;
        wait_clk(3);
        lnk.sce = 1'b0;
        wait_clk(4);

        // Function set / extended-mode Vop
        bv0 = bv_cnt;
        cmd(8'h21);
        check("ext_mode_set", ext_mode, 1);
        check("pd_clear", power_down, 0);
        cmd(8'hBF);
        check("vop", vop, 7'h3F);
        cmd(8'h20);
        check("ext_mode_clear", ext_mode, 0);
        check("pd_still_clear", power_down, 0);
        check("three_bytes", bv_cnt - bv0, 3);

        // Last cell write and wrap to origin
        cmd(8'h45);
        cmd(8'hD3);
        check("set_y5", y_addr, 5);
        check("set_x83", x_addr, 83);
        send_byte(8'hA5, 1'b1, 1'b1, 7'd83, 3'd5);
        check("wrap_x", x_addr, 0);
        check("wrap_y", y_addr, 0);
        read_fb(9'd503, FB ? 8'hA5 : 8'h00, "rd_503");

        // Vertical addressing
        cmd(8'h22);
        check("vaddr_mode", vaddr_mode, 1);
        cmd(8'h80);
        cmd(8'h45);
        send_byte(8'h11, 1'b1, 1'b1, 7'd0, 3'd5);
        send_byte(8'h22, 1'b1, 1'b1, 7'd1, 3'd0);
        check("vert_end_x", x_addr, 1);
        check("vert_end_y", y_addr, 1);
        read_fb(9'd420, FB ? 8'h11 : 8'h00, "rd_420");
        read_fb(9'd1, FB ? 8'h22 : 8'h00, "rd_1");

        // Aborted partial byte, then a clean byte
        fe0 = fe_cnt;
        send_bits(8'hF8, 5, 1'b0, 1'b0);
        wait_clk(2);
        lnk.sce = 1'b1;
        wait_clk(6);
        lnk.sce = 1'b0;
        wait_clk(6);
        cmd(8'h5A);
        check("frame_err_pulses", fe_cnt - fe0, 1);

        // Out-of-range pointer commands
        ce0 = ce_cnt;
        cmd(8'h47);
        cmd(8'hD4);
        check("cmd_err_pulses", ce_cnt - ce0, 2);
        check("err_keep_x", x_addr, 1);
        check("err_keep_y", y_addr, 1);

        // Horizontal end-of-row advance; X_MAX-1 accepted without error
        ce0 = ce_cnt;
        cmd(8'h20);
        cmd(8'hD3);
        cmd(8'h40);
        check("no_cmd_err_x83", ce_cnt - ce0, 0);
        send_byte(8'h77, 1'b1, 1'b1, 7'd83, 3'd0);
        check("row_adv_x", x_addr, 0);
        check("row_adv_y", y_addr, 1);
        read_fb(9'd83, FB ? 8'h77 : 8'h00, "rd_83");

        // LCD reset mid-session; byte sent during reset must be ignored
        cmd(8'h23);
        check("pre_res_h", ext_mode, 1);
        lnk.res = 1'b0;
        wait_clk(4);
        send_bits(8'hFF, 8, 1'b1, 1'b0);
        wait_clk(4);
        check("res_x", x_addr, 0);
        check("res_y", y_addr, 0);
        check("res_pd", power_down, 1);
        check("res_vop", vop, 0);
        check("res_v", vaddr_mode, 0);
        check("res_h", ext_mode, 0);
        lnk.res = 1'b1;
        wait_clk(6);
        read_fb(9'd503, FB ? 8'hA5 : 8'h00, "rd_503_after_res");

        // Reset mid-byte drops it silently; next byte assembles cleanly
        fe0 = fe_cnt;
        send_bits(8'hF0, 4, 1'b0, 1'b0);
        Reset = 1'b1;
        wait_clk(2);
        Reset = 1'b0;
        wait_clk(6);
        check("reset_mid_no_frame_err", fe_cnt - fe0, 0);
        cmd(8'h3C);
        read_fb(9'd420, FB ? 8'h11 : 8'h00, "rd_420_after_reset");

        wait_clk(10);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
